spi_master: RTL

SPI initiator for the FPGA-side link to the `SPI_slave` block. It drives `CS`, `SCLK` and `MOSI` from a divided system clock and shifts out one frame: a handshake bit followed by a `DATA_W`-bit payload, LSB first. It samples `MISO` on the same clock edges, so one frame carries both the command word out and the slave's reply in. It sits between the command/control logic, which issues `start` with `tx_data`, and the physical SPI pins.

---
 rtl/spi_master.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   SPI mode-0 initiator. One frame = handshake bit (constant 1) followed by a
//   DATA_W-bit payload, LSB first. MISO is sampled on every SCLK rise except
//   the handshake bit, so each frame also returns a DATA_W-bit reply.
//
// Parameters
//   DATA_W   payload bits per frame (1..16)
//   CLK_DIV  system-clock cycles per SCLK half-period (>= 1)
//
// Ports
//   clk_arduino  in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   start        in   frame request, accepted only while busy = 0
//   tx_data      in   payload, latched on the accepting edge
//   MISO         in   serial data from the slave
//   SCLK         out  SPI clock, idle low
//   MOSI         out  serial data to the slave
//   CS           out  chip select, active low
//   rx_data      out  last received payload, updated at frame end
//   busy         out  high from acceptance until frame end
//   done         out  one-cycle pulse at frame end
// -----------------------------------------------------------------------------
module spi_master #(
  parameter int DATA_W  = 4,
  parameter int CLK_DIV = 2
) (
  input  logic              clk_arduino,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              MISO,
  output logic              SCLK,
  output logic              MOSI,
  output logic              CS,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;   // bit index k; 0 is the handshake bit
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic              tick;      // last cycle of the current half-period
  logic              last_bit;

  assign tick     = (div_cnt == CNT_W'(CLK_DIV - 1));
  assign last_bit = (bit_cnt == BIT_W'(DATA_W));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_arduino or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (start) next_state = SHIFT;
      // A tick while SCLK is high is the falling toggle.
      SHIFT: if (tick && SCLK && last_bit) next_state = HOLD;
      HOLD:  if (tick) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Moore outputs decoded from state: CS drops and busy rises together on
  // the accepting edge and both release on the frame-end edge.
  always_comb begin
    CS   = (state == IDLE);
    busy = (state != IDLE);
  end

  // Datapath: divider, bit index, shift registers and registered pins.
  // NOTE: the shift registers are small flops, not RAM, so they are reset
  // along with everything else; a mid-frame reset leaves no stale data.
  always_ff @(posedge clk_arduino or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      SCLK     <= 1'b0;
      MOSI     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          if (start) begin
            tx_shift <= tx_data;
            MOSI     <= 1'b1;   // handshake bit
          end
        end

        SHIFT: begin
          if (tick) begin
            div_cnt <= '0;
            SCLK    <= ~SCLK;
            if (!SCLK) begin
              // Rising toggle: capture the reply, skipping the handshake bit.
              if (bit_cnt != '0) rx_shift <= DATA_W'({MISO, rx_shift} >> 1);
            end else if (last_bit) begin
              MOSI <= 1'b0;
            end else begin
              // Falling toggle: advance to the next payload bit.
              MOSI     <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        HOLD: begin
          if (tick) begin
            div_cnt <= '0;
            done    <= 1'b1;
            rx_data <= rx_shift;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: div_cnt <= '0;
      endcase
    end
  end

endmodule
